conv_window_streamer: RTL

- Upstream feeder for Convolution_Controller's AXI4-S data port.
- Takes a raster-order pixel frame (row by row, left to right) and re-emits it in column-window order. For each output band r (0..H-K), and for each column c (0..W-1), it emits pixels (r,c), (r+1,c), … (r+K-1,c), top to bottom.
- This is the order the controller consumes: one full K-column window first, then K new pixels per column step.
- Uses K-1 line buffers, so the host streams each pixel exactly once.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_line_buffer.sv | 22 ++
 rtl/conv_window_streamer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the column-window streamer: FSM states, default sizes
// and a constant-foldable clog2 used to size counters and RAM addresses.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ACCEPT,
        ST_EMIT,
        ST_CFG_ERR
    } state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned DEFAULT_KERNEL_SIZE = 3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of storage: single-port RAM with registered, read-before-write
// output so the old pixel at an address is visible in the cycle it is overwritten.
module conv_line_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wr_data;
        rd_data <= mem[addr];
    end

endmodule

// File: rtl/conv_window_streamer.sv
// Re-orders a raster pixel stream into K-tall column windows using K-1 line buffers.
// Optional `TLAST_CHECK_EN: checks s_axis_last against the frame geometry.
module conv_window_streamer
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
    parameter int unsigned MAX_WIDTH   = 1024,
    parameter int unsigned DIM_WIDTH   = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    cfg_enable,
    input  logic [DIM_WIDTH-1:0]    cfg_width,
    input  logic [DIM_WIDTH-1:0]    cfg_height,
    input  logic                    s_axis_valid,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    output logic                    s_axis_ready,
    input  logic                    s_axis_last,
    input  logic [DATA_WIDTH/8-1:0] s_axis_keep,
    output logic                    m_axis_valid,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    input  logic                    m_axis_ready,
    output logic                    m_axis_last,
    output logic [DATA_WIDTH/8-1:0] m_axis_keep,
    output logic                    frame_busy,
    output logic                    cfg_err,
    output logic                    frame_err
);

    localparam int unsigned K  = KERNEL_SIZE;
    localparam int unsigned AW = clog2(MAX_WIDTH);
    localparam int unsigned BW = clog2(K);

    state_t                 state, state_next;
    logic [DIM_WIDTH-1:0]   w_q, h_q, row_cnt, col_cnt;
    logic [BW-1:0]          beat;
    logic                   rd_valid;
    logic                   in_hs, out_hs;
    logic                   dims_legal, col_last, row_last, beat_last;
    logic [DATA_WIDTH-1:0]  emit_q  [K];
    logic [DATA_WIDTH-1:0]  rd_data [K-1];
    logic [DATA_WIDTH-1:0]  wr_data [K-1];
    logic                   buf_we  [K-1];
    logic                   tlast_bad;
    logic                   sideband_unused;

    assign sideband_unused = ^{s_axis_keep, s_axis_last};
    assign dims_legal = (32'(cfg_width) >= K) && (32'(cfg_width) <= MAX_WIDTH) &&
                        (32'(cfg_height) >= K);
    assign col_last   = (col_cnt == w_q - DIM_WIDTH'(1));
    assign row_last   = (row_cnt == h_q - DIM_WIDTH'(1));
    assign beat_last  = (beat == BW'(K - 1));
    assign m_axis_data = emit_q[beat];
    assign m_axis_keep = '1;
    assign frame_busy  = (state == ST_FILL) || (state == ST_ACCEPT) || (state == ST_EMIT);

    always_ff @(posedge Clk) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        s_axis_ready = 1'b0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        tlast_bad    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_enable) state_next = dims_legal ? ST_FILL : ST_CFG_ERR;
            end
            ST_FILL: begin
                s_axis_ready = 1'b1;
                if (s_axis_valid && col_last && (row_cnt == DIM_WIDTH'(K - 2)))
                    state_next = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                s_axis_ready = rd_valid;
                if (s_axis_valid && rd_valid) state_next = ST_EMIT;
            end
            ST_EMIT: begin
                m_axis_valid = 1'b1;
                m_axis_last  = beat_last && col_last && row_last;
                if (m_axis_ready && beat_last)
                    state_next = (col_last && row_last) ? ST_IDLE : ST_ACCEPT;
            end
            ST_CFG_ERR: begin
                if (!cfg_enable) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        in_hs  = s_axis_valid && s_axis_ready;
        out_hs = m_axis_valid && m_axis_ready;
`ifdef TLAST_CHECK_EN
        if (in_hs && (s_axis_last != (row_last && col_last))) tlast_bad = 1'b1;
        if (in_hs && s_axis_last && !(row_last && col_last)) state_next = ST_IDLE;
`endif
    end

    // ACCEPT spends one cycle with ready low so the RAM output reflects col_cnt.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            w_q      <= '0;
            h_q      <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            beat     <= '0;
            rd_valid <= 1'b0;
            cfg_err  <= 1'b0;
            for (int unsigned i = 0; i < K; i++) emit_q[i] <= '0;
        end else begin
            rd_valid <= (state == ST_ACCEPT) && !in_hs;
            case (state)
                ST_IDLE: begin
                    if (cfg_enable) begin
                        w_q     <= cfg_width;
                        h_q     <= cfg_height;
                        row_cnt <= '0;
                        col_cnt <= '0;
                        beat    <= '0;
                        if (!dims_legal) cfg_err <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (in_hs) begin
                        if (col_last) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + DIM_WIDTH'(1);
                        end else begin
                            col_cnt <= col_cnt + DIM_WIDTH'(1);
                        end
                    end
                end
                ST_ACCEPT: begin
                    if (in_hs) begin
                        for (int unsigned i = 0; i < K - 1; i++) emit_q[i] <= rd_data[i];
                        emit_q[K-1] <= s_axis_data;
                        beat        <= '0;
                    end
                end
                ST_EMIT: begin
                    if (out_hs) begin
                        if (beat_last) begin
                            beat <= '0;
                            if (col_last) begin
                                col_cnt <= '0;
                                row_cnt <= row_cnt + DIM_WIDTH'(1);
                            end else begin
                                col_cnt <= col_cnt + DIM_WIDTH'(1);
                            end
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TLAST_CHECK_EN
    always_ff @(posedge Clk) begin
        if (Rst)            frame_err <= 1'b0;
        else if (tlast_bad) frame_err <= 1'b1;
    end
`else
    assign frame_err = 1'b0;
`endif

    // Buffer i holds band row i; on ACCEPT each column shifts up one buffer.
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_line
        if (gi == K - 2) begin : g_top
            assign wr_data[gi] = s_axis_data;
        end else begin : g_mid
            assign wr_data[gi] = (state == ST_ACCEPT) ? rd_data[gi+1] : s_axis_data;
        end
        assign buf_we[gi] = in_hs && ((state == ST_ACCEPT) || (row_cnt == DIM_WIDTH'(gi)));

        conv_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (MAX_WIDTH),
            .ADDR_WIDTH (AW)
        ) u_buf (
            .clk     (Clk),
            .wr_en   (buf_we[gi]),
            .addr    (col_cnt[AW-1:0]),
            .wr_data (wr_data[gi]),
            .rd_data (rd_data[gi])
        );
    end

endmodule
